fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port res_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port redirect_valid  input  1  taken branch or jump this cycle.
REQ-005 The block SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-006 The block SHALL have port imem_req  output  1  instruction memory request.
REQ-007 The block SHALL have port imem_addr  output  32  request address, word aligned.
REQ-008 The block SHALL have port imem_ack  input  1  memory accepts and returns data this cycle; ack in the same cycle as req is legal.
REQ-009 The block SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 The block SHALL have port out_valid  output  1  out_pc/out_instr hold a fetched instruction.
REQ-011 The block SHALL have port out_ready  input  1  decode consumes the output this cycle.
REQ-012 The block SHALL have ports out_pc and out_instr  output  32 each  address and word of the held instruction.

Function
REQ-013 All outputs SHALL be registered; no input-to-output combinational path.
REQ-014 The FSM SHALL have states IDLE, REQ, FULL and DROP, with IDLE→REQ unconditionally one cycle after reset release.
REQ-015 On entering REQ, imem_addr SHALL be loaded with pc and imem_req SHALL be 1, held stable until imem_ack.
REQ-016 In REQ with imem_ack=1 and no redirect: out_instr←imem_rdata, out_pc←imem_addr, out_valid←1, pc←pc+4, imem_req←0, REQ→FULL.
REQ-017 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
REQ-018 In FULL, outputs SHALL stay stable while out_ready=0; when out_ready=1, out_valid←0 and FULL→REQ, so peak throughput is one instruction per 2 cycles.
REQ-019 When redirect_valid=1 in any non-IDLE state, pc SHALL be loaded with {redirect_pc[31:2],2'b00} and out_valid SHALL be cleared, with redirect taking priority over out_ready.
REQ-020 When redirect occurs in REQ with imem_ack=0, the FSM SHALL go to DROP, keeping imem_req=1 and the old imem_addr.
REQ-021 In DROP, the FSM SHALL wait for imem_ack, discard imem_rdata, and then go to REQ at the current pc.
REQ-022 When redirect occurs in REQ with imem_ack=1 in the same cycle, the data SHALL be discarded and the FSM SHALL go to REQ at the redirect pc.
REQ-023 When redirect occurs in DROP, pc SHALL be updated to the latest redirect target and the FSM SHALL stay in DROP.
REQ-024 When redirect occurs in FULL, the held instruction SHALL be dropped even if out_ready=1, and the FSM SHALL go to REQ.
REQ-025 When redirect occurs in IDLE, pc SHALL take the redirect target.

Reset
REQ-026 While res_n=0, the following SHALL hold immediately, independent of clk: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, out_valid=0, out_pc=0, out_instr=0.
REQ-027 Reset asserted mid-transaction SHALL abandon any outstanding request, and no stale data SHALL appear after release.

Structure
REQ-028 The FSM state typedef, the PC increment constant (4), and the RESET_PC default SHALL live in shared package core_pkg.
REQ-029 The block SHALL be a single module with no sub-modules, with the pc+4 adder inline.

Verification
REQ-030 Reset with RESET_PC=0 and an imem that always acks on the same cycle, out_ready=1: requests SHALL be 0x0, 0x4, 0x8 on every other cycle, and out_pc SHALL match.
REQ-031 Ack delayed 3 cycles, rdata=0x00000013: imem_req/imem_addr SHALL be stable for 4 cycles, then out_valid=1 with out_instr=0x00000013.
REQ-032 out_ready=0 for 5 cycles while FULL: outputs SHALL be stable and there SHALL be no new imem_req; then out_ready=1 → next request at pc+4.
REQ-033 Redirect to 0x100 while REQ awaits ack (ack 2 cycles later): DROP SHALL keep the old addr, the data SHALL be discarded, and the next request SHALL be 0x100 with no out_valid for the old address.
REQ-034 Redirect to 0x203 in the same cycle as ack: the data SHALL be discarded and the next imem_addr SHALL be 0x200.
REQ-035 pc=0xFFFFFFFC fetched: the next request SHALL be 0x00000000; and res_n pulsed low mid-REQ SHALL force all outputs to 0 asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch front end.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        DROP
    } fetch_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Single-request instruction fetch: one outstanding imem access and a
// one-entry output holding register, with branch redirect and stale-data drop.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         unused_low_bits;

    assign target          = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
            out_valid <= 1'b0;
            out_pc    <= 32'h0;
            out_instr <= 32'h0;
        end else begin
            // A redirect always retargets pc and kills any held instruction.
            if (redirect_valid) begin
                pc        <= target;
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_valid ? target : pc;
                end
                REQ: begin
                    if (redirect_valid) begin
                        // Acked data is for the old path; un-acked request must still drain.
                        if (imem_ack) imem_addr <= target;
                        else          state     <= DROP;
                    end else if (imem_ack) begin
                        out_instr <= imem_rdata;
                        out_pc    <= imem_addr;
                        out_valid <= 1'b1;
                        pc        <= pc + PC_INC;
                        imem_req  <= 1'b0;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (redirect_valid) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= target;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= redirect_valid ? target : pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by random traffic.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .res_n(res_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] exp_pc;
    logic        stale;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc = 32'h0;
        stale  = 1'b0;
    endtask

    // Drive one cycle of inputs and advance the reference model across the next edge.
    task automatic step(input logic ack, input logic rv, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] rdata);
        item_t it;
        imem_ack       = ack;
        redirect_valid = rv;
        redirect_pc    = tgt;
        out_ready      = rdy;
        imem_rdata     = rdata;
        if (rv) begin
            exp_pc = {tgt[31:2], 2'b00};
            if (imem_req) stale = !ack;
        end else if (imem_req && ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                chk("fetch_addr", imem_addr, exp_pc);
                it.pc    = exp_pc;
                it.instr = rdata;
                exp_q.push_back(it);
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        res_n          = 1'b0;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
    endtask

    // Monitor: samples just after each rising edge, while inputs still hold edge values.
    logic        pv, preq;
    logic [31:0] ppc, pinstr, paddr;
    initial begin
        item_t e;
        pv = 1'b0; preq = 1'b0; ppc = 32'h0; pinstr = 32'h0; paddr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!res_n) begin
                pv   = 1'b0;
                preq = 1'b0;
            end else begin
                if (out_valid && !pv) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", {31'h0, out_valid}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_instr", out_instr, e.instr);
                    end
                end
                if (pv && (out_ready || redirect_valid)) begin
                    chk("out_valid_clear", {31'h0, out_valid}, 32'h0);
                end else if (pv) begin
                    chk("hold_valid", {31'h0, out_valid}, 32'h1);
                    chk("hold_pc", out_pc, ppc);
                    chk("hold_instr", out_instr, pinstr);
                end
                if (out_valid) chk("no_req_while_full", {31'h0, imem_req}, 32'h0);
                if (preq && !imem_ack) begin
                    chk("req_hold", {31'h0, imem_req}, 32'h1);
                    chk("addr_hold", imem_addr, paddr);
                end
                pv = out_valid; ppc = out_pc; pinstr = out_instr;
                preq = imem_req; paddr = imem_addr;
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        model_reset();
        #2;
        chk("init_imem_req", {31'h0, imem_req}, 32'h0);
        chk("init_imem_addr", imem_addr, 32'h0);
        chk("init_out_valid", {31'h0, out_valid}, 32'h0);
        chk("init_out_pc", out_pc, 32'h0);
        chk("init_out_instr", out_instr, 32'h0);
        repeat (2) @(negedge clk);
        res_n = 1'b1;

        // Same-cycle ack, always ready: requests 0,4,8 on alternate cycles.
        step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
        for (int k = 0; k < 6; k++) begin
            chk("burst_req", {31'h0, imem_req}, (k % 2 == 0) ? 32'h1 : 32'h0);
            if (k % 2 == 0) chk("burst_addr", imem_addr, 32'(4 * (k / 2)));
            step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
        end

        // Ack after three wait cycles.
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, 32'hC);
            step(i == 3, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
        end
        chk("wait_valid", {31'h0, out_valid}, 32'h1);
        chk("wait_instr", out_instr, 32'h0000_0013);

        // Back-pressure for five cycles.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_pc", out_pc, 32'hC);
            chk("bp_req", {31'h0, imem_req}, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        chk("bp_next_addr", imem_addr, 32'h10);

        // Redirect while waiting for ack: drain the old access, then fetch 0x100.
        step(1'b0, 1'b1, 32'h100, 1'b1, $urandom);
        chk("drop_req", {31'h0, imem_req}, 32'h1);
        chk("drop_addr", imem_addr, 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
        chk("drop_no_valid", {31'h0, out_valid}, 32'h0);
        chk("drop_next_addr", imem_addr, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
        chk("redir_out_pc", out_pc, 32'h100);

        // Redirect coinciding with ack, unaligned target.
        step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        step(1'b1, 1'b1, 32'h203, 1'b1, $urandom);
        chk("same_cycle_valid", {31'h0, out_valid}, 32'h0);
        chk("same_cycle_addr", imem_addr, 32'h200);

        // Address wrap, then asynchronous reset in the middle of a request.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, $urandom);
        chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
        step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        chk("wrap_addr", imem_addr, 32'h0);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, tgt,
                 $urandom_range(0, 4) < 3, $urandom);
        end
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
